algo_1rw_a25_req_sched: RTL and testbench

Request front-end that drives the 1rw_a25 core's client interface (refr, rw_read, rw_write, rw_addr, rw_din).
- Accepts client requests on a valid/ready handshake and buffers them in a small FIFO.
- Inserts refresh slots at the refresh cadence the core requires and issues requests only in non-refresh slots while the core reports ready.
- Sits directly upstream of the core; all outputs are registered.

---
 rtl/algo_1rw_a25_pkg.sv | 17 +
 rtl/algo_1rw_a25_req_fifo.sv | 52 +++++
 rtl/algo_1rw_a25_req_sched.sv | 129 ++++++++++++
 tb/tb_algo_1rw_a25_req_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_1rw_a25_pkg.sv
// Shared definitions for the 1rw_a25 request scheduler: issue opcodes and
// the refresh-period rule.
package algo_1rw_a25_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_REFR  = 2'd1,
        OP_READ  = 2'd2,
        OP_WRITE = 2'd3
    } op_e;

    // With half-step enabled, odd phases stretch the period by one ready cycle.
    function automatic int refr_period(input int reffreq, input int reffrhf, input logic phase);
        return ((reffrhf != 0) && phase) ? reffreq + 1 : reffreq;
    endfunction

endpackage

// File: rtl/algo_1rw_a25_req_fifo.sv
// Request FIFO: registered count, pointer-based storage, no bypass.
// Latency 1 cycle push-to-visible head; pushes must be gated by !o_full, pops by !o_empty.
module algo_1rw_a25_req_fifo #(
    parameter int EW    = 46,
    parameter int DEPTH = 4,
    parameter int BITD  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [EW-1:0]   i_push_dat,
    input  logic            i_pop,
    output logic [EW-1:0]   o_head_dat,
    output logic            o_full,
    output logic            o_empty,
    output logic [BITD:0]   o_cnt
);

    logic [EW-1:0]   r_mem [DEPTH];
    logic [BITD-1:0] r_wptr;
    logic [BITD-1:0] r_rptr;
    logic [BITD:0]   r_cnt;

    assign o_full     = (r_cnt == (BITD+1)'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign o_cnt      = r_cnt;
    assign o_head_dat = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    // Pointers are BITD wide, so wrap modulo DEPTH comes for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/algo_1rw_a25_req_sched.sv
// Request scheduler in front of the 1rw_a25 core: buffers client requests and
// interleaves refresh slots; issue is registered (accept-to-issue >= 2 cycles).
// Backpressure: cl_rdy drops when the FIFO is full; core ready=0 freezes issue and refresh.
module algo_1rw_a25_req_sched
    import algo_1rw_a25_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int BITADDR  = 13,
    parameter int REFRESH  = 1,
    parameter int REFFREQ  = 6,
    parameter int REFFRHF  = 0,
    parameter int FIFODPTH = 4,
    parameter int BITFIFO  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cl_vld,
    output logic               cl_rdy,
    input  logic               cl_write,
    input  logic [BITADDR-1:0] cl_addr,
    input  logic [WIDTH-1:0]   cl_din,
    input  logic               ready,
    output logic               refr,
    output logic               rw_read,
    output logic               rw_write,
    output logic [BITADDR-1:0] rw_addr,
    output logic [WIDTH-1:0]   rw_din,
    output logic [BITFIFO:0]   fifo_cnt
);

    localparam int BITCNT = $clog2(REFFREQ + 2);

    typedef struct packed {
        logic               write;
        logic [BITADDR-1:0] addr;
        logic [WIDTH-1:0]   din;
    } req_t;

    req_t              w_push_dat;
    req_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_refr_slot;
    logic [BITCNT-1:0] w_period;
    op_e               w_op;

    logic [BITCNT-1:0]  r_cnt;
    logic               r_phase;
    logic               r_refr;
    logic               r_read;
    logic               r_write;
    logic [BITADDR-1:0] r_addr;
    logic [WIDTH-1:0]   r_din;

    assign cl_rdy     = !w_full && !rst;
    assign w_push     = cl_vld && cl_rdy;
    assign w_push_dat = '{write: cl_write, addr: cl_addr, din: cl_din};

    algo_1rw_a25_req_fifo #(
        .EW    ($bits(req_t)),
        .DEPTH (FIFODPTH),
        .BITD  (BITFIFO)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_cnt      (fifo_cnt)
    );

    assign w_period    = BITCNT'(refr_period(REFFREQ, REFFRHF, r_phase));
    assign w_refr_slot = (REFRESH != 0) && ready && (r_cnt == w_period - BITCNT'(1));

    // Refresh outranks any pending request in the same slot.
    always_comb begin
        w_op = OP_IDLE;
        if (ready) begin
            if (w_refr_slot)   w_op = OP_REFR;
            else if (!w_empty) w_op = w_head.write ? OP_WRITE : OP_READ;
        end
    end

    assign w_pop = (w_op == OP_READ) || (w_op == OP_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (ready) begin
            if (w_refr_slot) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refr  <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            r_refr  <= (w_op == OP_REFR);
            r_read  <= (w_op == OP_READ);
            r_write <= (w_op == OP_WRITE);
            if (w_pop) begin
                r_addr <= w_head.addr;
                r_din  <= w_head.din;
            end
        end
    end

    assign refr     = r_refr;
    assign rw_read  = r_read;
    assign rw_write = r_write;
    assign rw_addr  = r_addr;
    assign rw_din   = r_din;

endmodule

// File: tb/tb_algo_1rw_a25_req_sched.sv
// Bench for algo_1rw_a25_req_sched: three configurations (default, half-step, no refresh)
// share stimulus and are checked against a queue-based model every cycle.
module tb_algo_1rw_a25_req_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cl_vld;
    logic        cl_write;
    logic [12:0] cl_addr;
    logic [31:0] cl_din;
    logic        ready;

    logic        o_rdy  [3];
    logic        o_refr [3];
    logic        o_rd   [3];
    logic        o_wr   [3];
    logic [12:0] o_addr [3];
    logic [31:0] o_din  [3];
    logic [2:0]  o_cnt  [3];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    algo_1rw_a25_req_sched #(.REFRESH(1), .REFFRHF(0)) dut0 (
        .clk(clk), .rst(rst), .cl_vld(cl_vld), .cl_rdy(o_rdy[0]), .cl_write(cl_write),
        .cl_addr(cl_addr), .cl_din(cl_din), .ready(ready), .refr(o_refr[0]),
        .rw_read(o_rd[0]), .rw_write(o_wr[0]), .rw_addr(o_addr[0]), .rw_din(o_din[0]),
        .fifo_cnt(o_cnt[0]));
    algo_1rw_a25_req_sched #(.REFRESH(1), .REFFRHF(1)) dut1 (
        .clk(clk), .rst(rst), .cl_vld(cl_vld), .cl_rdy(o_rdy[1]), .cl_write(cl_write),
        .cl_addr(cl_addr), .cl_din(cl_din), .ready(ready), .refr(o_refr[1]),
        .rw_read(o_rd[1]), .rw_write(o_wr[1]), .rw_addr(o_addr[1]), .rw_din(o_din[1]),
        .fifo_cnt(o_cnt[1]));
    algo_1rw_a25_req_sched #(.REFRESH(0), .REFFRHF(0)) dut2 (
        .clk(clk), .rst(rst), .cl_vld(cl_vld), .cl_rdy(o_rdy[2]), .cl_write(cl_write),
        .cl_addr(cl_addr), .cl_din(cl_din), .ready(ready), .refr(o_refr[2]),
        .rw_read(o_rd[2]), .rw_write(o_wr[2]), .rw_addr(o_addr[2]), .rw_din(o_din[2]),
        .fifo_cnt(o_cnt[2]));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: a list of pending requests plus a ready-cycle counter per config.
    logic [45:0] m_q [3][64];
    int          m_hd  [3];
    int          m_tl  [3];
    int          m_cnt [3];
    int          m_ph  [3];
    logic        e_refr [3];
    logic        e_rd   [3];
    logic        e_wr   [3];
    logic [12:0] e_addr [3];
    logic [31:0] e_din  [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_hd[k] = 0; m_tl[k] = 0; m_cnt[k] = 0; m_ph[k] = 0;
                e_refr[k] = 0; e_rd[k] = 0; e_wr[k] = 0; e_addr[k] = 0; e_din[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int per;
                int occ;
                bit slot;
                logic [45:0] h;
                per  = 6 + ((k == 1) ? m_ph[k] : 0);
                slot = (k != 2) && ready && (m_cnt[k] == per - 1);
                occ  = m_tl[k] - m_hd[k];
                e_refr[k] = slot;
                e_rd[k]   = 0;
                e_wr[k]   = 0;
                if (ready && !slot && occ > 0) begin
                    h = m_q[k][m_hd[k] % 64];
                    m_hd[k]++;
                    e_wr[k]   = h[45];
                    e_rd[k]   = !h[45];
                    e_addr[k] = h[44:32];
                    e_din[k]  = h[31:0];
                end
                if (cl_vld && occ < 4) begin
                    m_q[k][m_tl[k] % 64] = {cl_write, cl_addr, cl_din};
                    m_tl[k]++;
                end
                if (ready) begin
                    if (slot) begin m_cnt[k] = 0; m_ph[k] = 1 - m_ph[k]; end
                    else m_cnt[k]++;
                end
            end
        end
    end

    logic [12:0] log_addr [256];
    logic        log_wr   [256];
    logic [31:0] log_din  [256];
    int          n_log = 0;

    always @(posedge clk) begin
        #3;
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("refr%0d", k), 64'(o_refr[k]), 64'(e_refr[k]));
                chk($sformatf("rd%0d", k),   64'(o_rd[k]),   64'(e_rd[k]));
                chk($sformatf("wr%0d", k),   64'(o_wr[k]),   64'(e_wr[k]));
                chk($sformatf("addr%0d", k), 64'(o_addr[k]), 64'(e_addr[k]));
                chk($sformatf("din%0d", k),  64'(o_din[k]),  64'(e_din[k]));
                chk($sformatf("cnt%0d", k),  64'(o_cnt[k]),  64'(m_tl[k] - m_hd[k]));
                chk($sformatf("rdy%0d", k),  64'(o_rdy[k]),  64'((m_tl[k] - m_hd[k]) < 4 && !rst));
                chk($sformatf("excl%0d", k),
                    64'((int'(o_refr[k]) + int'(o_rd[k]) + int'(o_wr[k])) <= 1), 64'(1));
            end
        end
        if ((o_rd[0] || o_wr[0]) && n_log < 256) begin
            log_addr[n_log] = o_addr[0];
            log_wr[n_log]   = o_wr[0];
            log_din[n_log]  = o_din[0];
            n_log++;
        end
    end

    task automatic drive_idle();
        cl_vld = 0; cl_write = 0; cl_addr = '0; cl_din = '0;
    endtask

    task automatic first_refr_after_release(input string tag);
        int t;
        int other;
        t = 0; other = 0;
        for (int c = 1; c <= 20 && t == 0; c++) begin
            @(negedge clk);
            if (o_refr[2] || o_rd[0] || o_wr[0]) other++;
            if (o_refr[0]) t = c;
        end
        chk({tag, "_first_refr"}, 64'(t), 64'(6));
        chk({tag, "_stray"}, 64'(other), 64'(0));
    endtask

    initial begin
        int t0 [16];
        int t1 [16];
        int n0, n1, n2, w;
        rst = 1; ready = 0; drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_strobes", 64'({o_refr[k], o_rd[k], o_wr[k]}), 64'(0));
            chk("rst_data", 64'({o_addr[k], o_din[k]}), 64'(0));
            chk("rst_cnt", 64'(o_cnt[k]), 64'(0));
            chk("rst_rdy", 64'(o_rdy[k]), 64'(0));
        end
        chk_en = 1;

        // Idle cadence for all three configurations.
        rst = 0; ready = 1;
        n0 = 0; n1 = 0; n2 = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (o_refr[0] && n0 < 16) begin t0[n0] = c; n0++; end
            if (o_refr[1] && n1 < 16) begin t1[n1] = c; n1++; end
            if (o_refr[2]) n2++;
        end
        chk("cad_first", 64'(t0[0]), 64'(6));
        for (int i = 1; i < 8; i++) chk("cad_gap", 64'(t0[i] - t0[i-1]), 64'(6));
        chk("hf_first", 64'(t1[0]), 64'(6));
        for (int i = 1; i < 8; i++) chk("hf_gap", 64'(t1[i] - t1[i-1]), 64'((i % 2 == 1) ? 7 : 6));
        chk("norefr_cnt", 64'(n2), 64'(0));

        // Ready freeze with the counter parked at 4.
        w = 0;
        while (m_cnt[0] != 4 && w < 20) begin @(negedge clk); w++; end
        chk("frz_wait", 64'(m_cnt[0] == 4), 64'(1));
        ready = 0;
        repeat (3) begin
            @(negedge clk);
            chk("frz_quiet", 64'({o_refr[0], o_rd[0], o_wr[0]}), 64'(0));
        end
        ready = 1;
        @(negedge clk);
        chk("frz_refr_early", 64'(o_refr[0]), 64'(0));
        @(negedge clk);
        chk("frz_refr", 64'(o_refr[0]), 64'(1));

        // Backpressure: five pushes into a depth-4 FIFO with the core stalled.
        ready = 0; n_log = 0;
        for (int i = 0; i < 5; i++) begin
            cl_vld = 1; cl_write = i[0]; cl_addr = 13'h100 + 13'(i); cl_din = $urandom;
            #1 chk("bp_rdy", 64'(o_rdy[0]), 64'(i < 4));
            @(negedge clk);
        end
        drive_idle();
        chk("bp_cnt", 64'(o_cnt[0]), 64'(4));
        ready = 1;
        w = 0;
        while (n_log == 0 && w < 20) begin @(negedge clk); w++; end
        chk("bp_rdy_after_pop", 64'(o_rdy[0]), 64'(1));
        while (n_log < 4 && w < 30) begin @(negedge clk); w++; end
        chk("bp_issued", 64'(n_log), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("bp_addr", 64'(log_addr[i]), 64'(13'h100 + 13'(i)));
            chk("bp_wr", 64'(log_wr[i]), 64'(i % 2));
        end

        // Streaming alternating write/read.
        repeat (6) @(negedge clk);
        n_log = 0;
        for (int i = 0; i < 12; i++) begin
            cl_vld = 1; cl_write = (i % 2 == 0); cl_addr = 13'(i); cl_din = 32'(i * 32'h11);
            w = 0;
            while (!o_rdy[0] && w < 20) begin @(negedge clk); w++; end
            chk("st_push_wait", 64'(o_rdy[0]), 64'(1));
            @(negedge clk);
        end
        drive_idle();
        w = 0;
        while (n_log < 12 && w < 60) begin @(negedge clk); w++; end
        chk("st_issued", 64'(n_log), 64'(12));
        for (int i = 0; i < 12; i++) begin
            chk("st_addr", 64'(log_addr[i]), 64'(i));
            chk("st_wr", 64'(log_wr[i]), 64'(i % 2 == 0));
            chk("st_din", 64'(log_din[i]), 64'(i * 17));
        end

        // Reset in the middle of traffic.
        rst = 1; @(negedge clk); rst = 0; ready = 0;
        for (int i = 0; i < 4; i++) begin
            cl_vld = 1; cl_write = 1; cl_addr = 13'h1f0 + 13'(i); cl_din = $urandom;
            @(negedge clk);
        end
        drive_idle();
        ready = 1;
        @(negedge clk);
        ready = 0;
        chk("mid_wr_before", 64'(o_wr[0]), 64'(1));
        chk("mid_cnt_before", 64'(o_cnt[0]), 64'(3));
        rst = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_strobes", 64'({o_refr[k], o_rd[k], o_wr[k]}), 64'(0));
            chk("mid_cnt", 64'(o_cnt[k]), 64'(0));
            chk("mid_rdy", 64'(o_rdy[k]), 64'(0));
        end
        @(negedge clk);
        rst = 0; ready = 1;
        first_refr_after_release("mid");

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cl_vld   = ($urandom % 2) == 0;
            cl_write = $urandom % 2;
            cl_addr  = 13'($urandom);
            cl_din   = $urandom;
            ready    = ($urandom % 8) != 0;
        end
        drive_idle();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
